// File: rtl/scatter_buf.sv
// scatter_buf: in-order circular buffer that takes a compacted stream of up
// to IN entries per cycle and, on each accepted request, expands the oldest
// entries onto the lanes selected by a destination mask (ascending lane order).
module scatter_buf #(
  parameter int DATA  = 32,
  parameter int IN    = 4,
  parameter int OUT   = 8,
  parameter int DEPTH = 16,
  parameter bit ACT   = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset_,
  input  logic [$clog2(IN):0]            push_cnt,
  input  logic [IN-1:0][DATA-1:0]        push_data,
  output logic                           push_ready,
  input  logic                           req,
  input  logic [OUT-1:0]                 req_mask,
  output logic                           req_ready,
  output logic                           out_valid,
  output logic [OUT-1:0]                 out_mask,
  output logic [OUT-1:0][DATA-1:0]       out_data,
  input  logic                           out_ready,
  output logic [$clog2(DEPTH):0]         count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(IN) + 1;

  logic [DATA-1:0]            mem [DEPTH];
  logic [AW-1:0]              wr_ptr_reg;
  logic [AW-1:0]              rd_ptr_reg;
  logic [CW-1:0]              count_reg;
  logic                       out_valid_reg;
  logic [OUT-1:0]             out_mask_reg;
  logic [OUT-1:0][DATA-1:0]   out_data_reg;

  logic [OUT-1:0]             req_en;
  logic                       valid_en;
  logic [CW-1:0]              pop_cnt;
  logic [AW-1:0]              rank [OUT];
  logic [CW-1:0]              free_cnt;
  logic                       push_take;
  logic                       slot_free;
  logic                       accept;
  logic [CW-1:0]              push_add;
  logic [CW-1:0]              pop_sub;
  logic [OUT-1:0][DATA-1:0]   lane_next;

  // Normalise polarity so the datapath always works with active-high bits.
  assign req_en   = req_mask ^ {OUT{~ACT}};
  assign valid_en = (out_valid_reg == ACT);

  // Popcount of the request mask and, per lane, the count of enabled lanes below it.
  always_comb begin
    pop_cnt = '0;
    for (int j = 0; j < OUT; j++) begin
      rank[j] = pop_cnt[AW-1:0];
      pop_cnt = pop_cnt + CW'(req_en[j]);
    end
  end

  // Free space is taken from registered occupancy only, so push_ready has no input path.
  assign free_cnt   = CW'(DEPTH) - count_reg;
  assign push_ready = (free_cnt >= CW'(IN));
  assign push_take  = push_ready && (push_cnt != '0);

  // The output slot frees either when empty or when the consumer drains it this cycle.
  assign slot_free = !valid_en || out_ready;
  assign req_ready = slot_free && (count_reg >= pop_cnt);
  assign accept    = req && req_ready;

  assign push_add = push_take ? CW'(push_cnt) : '0;
  assign pop_sub  = accept ? pop_cnt : '0;

  // Each lane picks the entry at its rank past the read pointer; disabled lanes carry zero.
  for (genvar gi = 0; gi < OUT; gi++) begin : g_lane
    assign lane_next[gi] = req_en[gi] ? mem[rd_ptr_reg + rank[gi]] : '0;
  end

  // Storage write: entries 0..push_cnt-1 land at consecutive slots from the write pointer.
  always_ff @(posedge clk) begin
    if (push_take) begin
      for (int k = 0; k < IN; k++) begin
        if (IW'(k) < push_cnt) begin
          mem[wr_ptr_reg + AW'(k)] <= push_data[k];
        end
      end
    end
  end

  // Pointer and occupancy update; push and pop may happen in the same cycle.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      count_reg <= count_reg + push_add - pop_sub;
      if (push_take) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(push_cnt);
      end
      if (accept) begin
        rd_ptr_reg <= rd_ptr_reg + pop_cnt[AW-1:0];
      end
    end
  end

  // Output beat register: load on accept, hold under backpressure, retire when drained.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      out_valid_reg <= ~ACT;
      out_mask_reg  <= {OUT{~ACT}};
      out_data_reg  <= '0;
    end else if (accept) begin
      out_valid_reg <= ACT;
      out_mask_reg  <= req_mask;
      out_data_reg  <= lane_next;
    end else if (valid_en && out_ready) begin
      out_valid_reg <= ~ACT;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_mask  = out_mask_reg;
  assign out_data  = out_data_reg;
  assign count     = count_reg;

endmodule

// File: tb/tb_scatter_buf.sv
// Testbench for scatter_buf: directed scenarios plus randomized traffic,
// checked against a queue-based reference model.
module tb_scatter_buf;

  logic             clk = 1'b0;
  logic             reset_;
  logic [2:0]       push_cnt;
  logic [3:0][7:0]  push_data;
  logic             push_ready;
  logic             req;
  logic [7:0]       req_mask;
  logic             req_ready;
  logic             out_valid;
  logic [7:0]       out_mask;
  logic [7:0][7:0]  out_data;
  logic             out_ready;
  logic [4:0]       count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: FIFO contents plus the expected output beat.
  byte unsigned     q[$];
  logic             exp_valid;
  logic [7:0]       exp_mask;
  logic [7:0][7:0]  exp_data;

  always #5 clk = ~clk;

  scatter_buf #(.DATA(8), .IN(4), .OUT(8), .DEPTH(16), .ACT(1'b1)) dut (
    .clk(clk), .reset_(reset_),
    .push_cnt(push_cnt), .push_data(push_data), .push_ready(push_ready),
    .req(req), .req_mask(req_mask), .req_ready(req_ready),
    .out_valid(out_valid), .out_mask(out_mask), .out_data(out_data),
    .out_ready(out_ready), .count(count)
  );

  function automatic logic m_push_ready();
    return (16 - q.size()) >= 4;
  endfunction

  function automatic logic m_req_ready();
    return ((!exp_valid) || out_ready) && (q.size() >= $countones(req_mask));
  endfunction

  task automatic model_reset();
    q.delete();
    exp_valid = 1'b0;
    exp_mask  = 8'h00;
    exp_data  = '0;
  endtask

  // Advance the model with the current inputs, then clock the DUT.
  task automatic step();
    logic acc, tk;
    acc = req && m_req_ready();
    tk  = (push_cnt != 3'd0) && m_push_ready();
    if (acc) begin
      for (int j = 0; j < 8; j++) begin
        if (req_mask[j]) exp_data[j] = q.pop_front();
        else             exp_data[j] = 8'h00;
      end
      exp_valid = 1'b1;
      exp_mask  = req_mask;
    end else if (exp_valid && out_ready) begin
      exp_valid = 1'b0;
    end
    if (tk) begin
      for (int k = 0; k < int'(push_cnt); k++) q.push_back(push_data[k]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_ = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_ = 1'b1;
  endtask

  task automatic test_reset();
    push_cnt = 3'd0; push_data = '0; req = 1'b0; req_mask = 8'h00; out_ready = 1'b1;
    reset_ = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_mask !== 8'h00) $display("FAIL reset_out_mask: got %h want 00", out_mask); else pass_cnt++;
    total_cnt++; if (out_data !== 64'h0) $display("FAIL reset_out_data: got %h want 0", out_data); else pass_cnt++;
    total_cnt++; if (count !== 5'd0) $display("FAIL reset_count: got %0d want 0", count); else pass_cnt++;
    total_cnt++; if (push_ready !== 1'b1) $display("FAIL reset_push_ready: got %0b want 1", push_ready); else pass_cnt++;
    reset_ = 1'b1;
    #1;
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready_empty_mask: got %0b want 1", req_ready); else pass_cnt++;
    req_mask = 8'h01;
    #1;
    total_cnt++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready_mask01: got %0b want 0", req_ready); else pass_cnt++;
    req_mask = 8'h00;
    step();
  endtask

  task automatic test_basic();
    push_cnt = 3'd3; push_data = {8'h00, 8'h33, 8'h22, 8'h11};
    step();
    push_cnt = 3'd0;
    req = 1'b1; req_mask = 8'b1010_0100;
    #1;
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL basic_req_ready: got %0b want 1", req_ready); else pass_cnt++;
    step();
    req = 1'b0; req_mask = 8'h00;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL basic_valid: got %0b want 1", out_valid); else pass_cnt++;
    total_cnt++; if (out_mask !== 8'hA4) $display("FAIL basic_mask: got %h want a4", out_mask); else pass_cnt++;
    total_cnt++; if (out_data !== 64'h3300_2200_0011_0000) $display("FAIL basic_data: got %h want 3300220000110000", out_data); else pass_cnt++;
    total_cnt++; if (count !== 5'd0) $display("FAIL basic_count: got %0d want 0", count); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_valid_drop: got %0b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_insufficient();
    push_cnt = 3'd2; push_data = {8'h00, 8'h00, 8'h55, 8'h44};
    step();
    push_cnt = 3'd0;
    req = 1'b1; req_mask = 8'h07;
    #1;
    total_cnt++; if (req_ready !== 1'b0) $display("FAIL insuff_req_ready: got %0b want 0", req_ready); else pass_cnt++;
    step();
    total_cnt++; if (count !== 5'd2) $display("FAIL insuff_count_hold: got %0d want 2", count); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL insuff_no_beat: got %0b want 0", out_valid); else pass_cnt++;
    push_cnt = 3'd1; push_data = {8'h00, 8'h00, 8'h00, 8'h66};
    #1;
    total_cnt++; if (req_ready !== 1'b0) $display("FAIL insuff_no_bypass: got %0b want 0", req_ready); else pass_cnt++;
    step();
    push_cnt = 3'd0;
    #1;
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL insuff_req_ready_after_push: got %0b want 1", req_ready); else pass_cnt++;
    step();
    req = 1'b0; req_mask = 8'h00;
    total_cnt++; if (out_data !== 64'h0000_0000_0066_5544) $display("FAIL insuff_data: got %h want 665544", out_data); else pass_cnt++;
    total_cnt++; if (out_mask !== 8'h07) $display("FAIL insuff_mask: got %h want 07", out_mask); else pass_cnt++;
    total_cnt++; if (count !== 5'd0) $display("FAIL insuff_count: got %0d want 0", count); else pass_cnt++;
    step();
  endtask

  task automatic test_backpressure();
    push_cnt = 3'd4; push_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    step();
    push_data = {8'hA7, 8'hA6, 8'hA5, 8'hA4};
    step();
    push_cnt = 3'd0;
    req = 1'b1; req_mask = 8'h03;
    step();
    out_ready = 1'b0; req_mask = 8'h0C;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++; if (req_ready !== 1'b0) $display("FAIL bp_req_ready_%0d: got %0b want 0", i, req_ready); else pass_cnt++;
      step();
      total_cnt++; if (out_valid !== 1'b1 || out_mask !== 8'h03 || out_data !== 64'h0000_0000_0000_A1A0)
        $display("FAIL bp_hold_%0d: got v=%0b m=%h d=%h want v=1 m=03 d=a1a0", i, out_valid, out_mask, out_data); else pass_cnt++;
    end
    out_ready = 1'b1;
    #1;
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL bp_release_req_ready: got %0b want 1", req_ready); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b1 || out_mask !== 8'h0C || out_data !== 64'h0000_0000_A3A2_0000)
      $display("FAIL bp_beat2: got v=%0b m=%h d=%h want v=1 m=0c d=a3a20000", out_valid, out_mask, out_data); else pass_cnt++;
    req_mask = 8'h30;
    step();
    total_cnt++; if (out_valid !== 1'b1 || out_mask !== 8'h30 || out_data !== 64'h0000_A5A4_0000_0000)
      $display("FAIL bp_beat3: got v=%0b m=%h d=%h want v=1 m=30 d=a5a400000000", out_valid, out_mask, out_data); else pass_cnt++;
    req_mask = 8'h81;
    step();
    req = 1'b0; req_mask = 8'h00;
    total_cnt++; if (out_data !== 64'hA700_0000_0000_00A6 || count !== 5'd0)
      $display("FAIL bp_drain: got d=%h c=%0d want d=a7000000000000a6 c=0", out_data, count); else pass_cnt++;
    step();
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int b = 0; b < 4; b++) begin
      push_cnt = 3'd4;
      for (int k = 0; k < 4; k++) push_data[k] = 8'(b * 4 + k);
      step();
    end
    total_cnt++; if (count !== 5'd16) $display("FAIL wrap_full_count: got %0d want 16", count); else pass_cnt++;
    total_cnt++; if (push_ready !== 1'b0) $display("FAIL wrap_full_push_ready: got %0b want 0", push_ready); else pass_cnt++;
    push_data = {8'hEE, 8'hEE, 8'hEE, 8'hEE};
    step();
    push_cnt = 3'd0;
    total_cnt++; if (count !== 5'd16) $display("FAIL wrap_push_ignored: got %0d want 16", count); else pass_cnt++;
    req = 1'b1; req_mask = 8'hFF;
    step();
    req = 1'b0;
    total_cnt++; if (out_data !== 64'h0706_0504_0302_0100 || count !== 5'd8)
      $display("FAIL wrap_beat1: got d=%h c=%0d want d=0706050403020100 c=8", out_data, count); else pass_cnt++;
    push_cnt = 3'd4; push_data = {8'h13, 8'h12, 8'h11, 8'h10};
    step();
    push_cnt = 3'd0;
    req = 1'b1; req_mask = 8'hFF;
    step();
    total_cnt++; if (out_data !== 64'h0F0E_0D0C_0B0A_0908 || count !== 5'd4)
      $display("FAIL wrap_beat2: got d=%h c=%0d want d=0f0e0d0c0b0a0908 c=4", out_data, count); else pass_cnt++;
    req_mask = 8'h0F;
    step();
    req = 1'b0; req_mask = 8'h00;
    total_cnt++; if (out_data !== 64'h0000_0000_1312_1110 || out_mask !== 8'h0F || count !== 5'd0)
      $display("FAIL wrap_beat3: got d=%h m=%h c=%0d want d=13121110 m=0f c=0", out_data, out_mask, count); else pass_cnt++;
    step();
  endtask

  task automatic test_simul_and_reset();
    push_cnt = 3'd4; push_data = {8'h24, 8'h23, 8'h22, 8'h21};
    step();
    push_cnt = 3'd1; push_data = {8'h00, 8'h00, 8'h00, 8'h25};
    step();
    push_cnt = 3'd4; push_data = {8'h34, 8'h33, 8'h32, 8'h31};
    req = 1'b1; req_mask = 8'h07;
    #1;
    total_cnt++; if (push_ready !== 1'b1 || req_ready !== 1'b1)
      $display("FAIL simul_ready: got pr=%0b rr=%0b want 1 1", push_ready, req_ready); else pass_cnt++;
    step();
    push_cnt = 3'd0; req = 1'b0; req_mask = 8'h00; out_ready = 1'b0;
    total_cnt++; if (count !== 5'd6) $display("FAIL simul_count: got %0d want 6", count); else pass_cnt++;
    total_cnt++; if (out_data !== 64'h0000_0000_0023_2221) $display("FAIL simul_data: got %h want 232221", out_data); else pass_cnt++;
    step();
    reset_ = 1'b0;
    model_reset();
    #1;
    total_cnt++; if (out_valid !== 1'b0 || count !== 5'd0 || out_mask !== 8'h00 || out_data !== 64'h0)
      $display("FAIL async_reset: got v=%0b c=%0d m=%h d=%h want all 0", out_valid, count, out_mask, out_data); else pass_cnt++;
    @(posedge clk);
    #1;
    reset_ = 1'b1; out_ready = 1'b1;
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      push_cnt  = 3'($urandom_range(0, 4));
      push_data = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      req       = 1'($urandom);
      req_mask  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom & $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      total_cnt++; if (req_ready !== m_req_ready()) $display("FAIL rnd_req_ready[%0d]: got %0b want %0b", i, req_ready, m_req_ready()); else pass_cnt++;
      total_cnt++; if (push_ready !== m_push_ready()) $display("FAIL rnd_push_ready[%0d]: got %0b want %0b", i, push_ready, m_push_ready()); else pass_cnt++;
      step();
      total_cnt++; if (count !== 5'(q.size())) $display("FAIL rnd_count[%0d]: got %0d want %0d", i, count, q.size()); else pass_cnt++;
      total_cnt++; if (out_valid !== exp_valid || out_mask !== exp_mask || out_data !== exp_data)
        $display("FAIL rnd_beat[%0d]: got v=%0b m=%h d=%h want v=%0b m=%h d=%h", i, out_valid, out_mask, out_data, exp_valid, exp_mask, exp_data);
      else pass_cnt++;
    end
    push_cnt = 3'd0; req = 1'b0; req_mask = 8'h00; out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_insufficient();
    test_backpressure();
    test_wrap();
    test_simul_and_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
